// File: rtl/rv32i_pkg.sv
// Shared core definitions: register address type, zero-register constant and popcount.
// Pure declarations, no logic of its own.
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int POPCNT_W = 64;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic [6:0] popcount(input logic [POPCNT_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback, flush wins.
// pending_o and cnt_o are registered and move together on the same edge; no backpressure.
module reg_scoreboard
  import rv32i_pkg::*;
#(
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_i,
  input  logic [AW-1:0]   set_addr_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_addr_i,
  input  logic            flush_i,
  output logic [NREG-1:0] pending_o,
  output logic [AW:0]     cnt_o
);

  logic [NREG-1:0]     r_pending;
  logic [AW:0]         r_cnt;
  logic [NREG-1:0]     w_next;
  logic [POPCNT_W-1:0] w_next_ext;

  // Order matters: the issue is younger than the writeback, and a flush squashes both marks.
  always_comb begin
    w_next = r_pending;
    if (clr_i) w_next[clr_addr_i] = 1'b0;
    if (set_i) w_next[set_addr_i] = 1'b1;
    if (flush_i) w_next = '0;
    w_next[0] = 1'b0;
  end

  assign w_next_ext = POPCNT_W'(w_next);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_next;
      r_cnt     <= (AW+1)'(popcount(w_next_ext));
    end
  end

  assign pending_o = r_pending;
  assign cnt_o     = r_cnt;

endmodule

// File: rtl/fwd_regfile.sv
// Multi-port register file with write-through bypass and RAW hazard detection (stall_o).
// Reads are combinational (0 cycles), writes/pending marks land on the next edge; stall_o is the backpressure.
module fwd_regfile
  import rv32i_pkg::*;
#(
  parameter  int XLEN = rv32i_pkg::XLEN,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [NRD*AW-1:0] raddr_i,
  input  logic [NRD-1:0]    rvalid_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  input  logic              issue_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              flush_i,
  output logic [NRD-1:0]    busy_o,
  output logic              stall_o,
  output logic [AW:0]       pending_cnt_o
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_pending;
  logic            w_wr_en;

  assign w_wr_en = write_i && (waddr_i != AW'(REG_ZERO));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (issue_i),
    .set_addr_i (issue_rd_i),
    .clr_i      (write_i),
    .clr_addr_i (waddr_i),
    .flush_i    (flush_i),
    .pending_o  (w_pending),
    .cnt_o      (pending_cnt_o)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_raddr;
    logic          w_addr_match;

    assign w_raddr      = raddr_i[k*AW +: AW];
    assign w_addr_match = write_i && (waddr_i == w_raddr);

    // x0 is never bypassed so a discarded write to it cannot leak onto a read port.
    assign rdata_o[k*XLEN +: XLEN] = (w_addr_match && (w_raddr != AW'(REG_ZERO)))
                                     ? wdata_i : r_regs[w_raddr];
    assign busy_o[k] = w_pending[w_raddr] && !w_addr_match;
  end

  assign stall_o = |(busy_o & rvalid_i);

endmodule

// File: tb/tb_fwd_regfile.sv
// Directed bench for fwd_regfile with four read ports; each task drives a scenario and checks inline.
// Inputs change 1 ns after the rising edge and outputs are sampled 1 ns after that.
module tb_fwd_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = 5;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 write_i;
  logic [AW-1:0]        waddr_i;
  logic [XLEN-1:0]      wdata_i;
  logic [NRD*AW-1:0]    raddr_i;
  logic [NRD-1:0]       rvalid_i;
  logic [NRD*XLEN-1:0]  rdata_o;
  logic                 issue_i;
  logic [AW-1:0]        issue_rd_i;
  logic                 flush_i;
  logic [NRD-1:0]       busy_o;
  logic                 stall_o;
  logic [AW:0]          pending_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  fwd_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .write_i       (write_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .raddr_i       (raddr_i),
    .rvalid_i      (rvalid_i),
    .rdata_o       (rdata_o),
    .issue_i       (issue_i),
    .issue_rd_i    (issue_rd_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .stall_o       (stall_o),
    .pending_cnt_o (pending_cnt_o)
  );

  function automatic logic [NRD*AW-1:0] pk(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [XLEN-1:0] rd(input int k);
    return rdata_o[k*XLEN +: XLEN];
  endfunction

  task automatic idle();
    write_i    = 1'b0;
    waddr_i    = '0;
    wdata_i    = '0;
    issue_i    = 1'b0;
    issue_rd_i = '0;
    flush_i    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    idle();
    raddr_i  = pk(5'd1, 5'd2, 5'd3, 5'd4);
    rvalid_i = 4'b1111;
    #1;
    n_total++;
    if (rdata_o !== '0) $display("FAIL reset_rdata: got %h want 0", rdata_o); else n_pass++;
    n_total++;
    if (busy_o !== 4'b0000 || stall_o !== 1'b0)
      $display("FAIL reset_busy: busy=%b stall=%b want 0000/0", busy_o, stall_o);
    else n_pass++;
    n_total++;
    if (pending_cnt_o !== 6'd0) $display("FAIL reset_cnt: got %0d want 0", pending_cnt_o); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_bypass();
    write_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF;
    raddr_i = pk(5'd5, 5'd0, 5'd0, 5'd0); rvalid_i = 4'b0001;
    #1;
    n_total++;
    if (rd(0) !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle: got %h want deadbeef", rd(0)); else n_pass++;
    step();
    idle();
    #1;
    n_total++;
    if (rd(0) !== 32'hDEADBEEF) $display("FAIL bypass_stored: got %h want deadbeef", rd(0)); else n_pass++;
  endtask

  task automatic test_x0();
    write_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h1234;
    issue_i = 1'b1; issue_rd_i = 5'd0;
    raddr_i = pk(5'd0, 5'd0, 5'd0, 5'd0); rvalid_i = 4'b1111;
    #1;
    n_total++;
    if (rd(0) !== 32'h0) $display("FAIL x0_no_bypass: got %h want 0", rd(0)); else n_pass++;
    step();
    idle();
    #1;
    n_total++;
    if (rd(0) !== 32'h0 || rd(3) !== 32'h0) $display("FAIL x0_read: got %h/%h want 0", rd(0), rd(3)); else n_pass++;
    n_total++;
    if (busy_o !== 4'b0000 || pending_cnt_o !== 6'd0)
      $display("FAIL x0_pending: busy=%b cnt=%0d want 0000/0", busy_o, pending_cnt_o);
    else n_pass++;
  endtask

  task automatic test_raw_hazard();
    issue_i = 1'b1; issue_rd_i = 5'd7;
    step();
    idle();
    raddr_i = pk(5'd0, 5'd7, 5'd0, 5'd0); rvalid_i = 4'b0010;
    #1;
    n_total++;
    if (busy_o !== 4'b0010 || stall_o !== 1'b1 || pending_cnt_o !== 6'd1)
      $display("FAIL raw_busy: busy=%b stall=%b cnt=%0d want 0010/1/1", busy_o, stall_o, pending_cnt_o);
    else n_pass++;
    rvalid_i = 4'b1101;
    #1;
    n_total++;
    if (busy_o !== 4'b0010 || stall_o !== 1'b0)
      $display("FAIL raw_rvalid_gate: busy=%b stall=%b want 0010/0", busy_o, stall_o);
    else n_pass++;
    rvalid_i = 4'b0010;
    write_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h42;
    #1;
    n_total++;
    if (busy_o !== 4'b0000 || stall_o !== 1'b0 || rd(1) !== 32'h42)
      $display("FAIL raw_write_clears: busy=%b stall=%b rdata1=%h want 0000/0/42", busy_o, stall_o, rd(1));
    else n_pass++;
    step();
    idle();
    #1;
    n_total++;
    if (pending_cnt_o !== 6'd0 || rd(1) !== 32'h42)
      $display("FAIL raw_after_write: cnt=%0d rdata1=%h want 0/42", pending_cnt_o, rd(1));
    else n_pass++;
  endtask

  task automatic test_flush();
    issue_i = 1'b1; issue_rd_i = 5'd3; step();
    issue_rd_i = 5'd4; step();
    issue_rd_i = 5'd9; step();
    idle();
    raddr_i = pk(5'd3, 5'd4, 5'd9, 5'd10); rvalid_i = 4'b0000;
    #1;
    n_total++;
    if (pending_cnt_o !== 6'd3 || busy_o !== 4'b0111)
      $display("FAIL flush_pre: cnt=%0d busy=%b want 3/0111", pending_cnt_o, busy_o);
    else n_pass++;
    flush_i = 1'b1; issue_i = 1'b1; issue_rd_i = 5'd10;
    write_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h99;
    step();
    idle();
    #1;
    n_total++;
    if (pending_cnt_o !== 6'd0 || busy_o !== 4'b0000)
      $display("FAIL flush_post: cnt=%0d busy=%b want 0/0000", pending_cnt_o, busy_o);
    else n_pass++;
    n_total++;
    if (rd(0) !== 32'h99) $display("FAIL flush_write_kept: got %h want 99", rd(0)); else n_pass++;
  endtask

  task automatic test_same_edge();
    write_i = 1'b1; waddr_i = 5'd6; wdata_i = 32'h55;
    issue_i = 1'b1; issue_rd_i = 5'd6;
    raddr_i = pk(5'd6, 5'd6, 5'd6, 5'd6); rvalid_i = 4'b0001;
    step();
    idle();
    #1;
    for (int k = 0; k < NRD; k++) begin
      n_total++;
      if (rd(k) !== 32'h55) $display("FAIL same_edge_rdata%0d: got %h want 55", k, rd(k)); else n_pass++;
    end
    n_total++;
    if (busy_o !== 4'b1111 || stall_o !== 1'b1 || pending_cnt_o !== 6'd1)
      $display("FAIL same_edge_busy: busy=%b stall=%b cnt=%0d want 1111/1/1", busy_o, stall_o, pending_cnt_o);
    else n_pass++;
    issue_i = 1'b1; issue_rd_i = 5'd6;
    step();
    idle();
    #1;
    n_total++;
    if (pending_cnt_o !== 6'd1) $display("FAIL reissue_cnt: got %0d want 1", pending_cnt_o); else n_pass++;
    write_i = 1'b1; waddr_i = 5'd6; wdata_i = 32'h66;
    step();
    idle();
    #1;
    n_total++;
    if (pending_cnt_o !== 6'd0 || rd(2) !== 32'h66)
      $display("FAIL reissue_clear: cnt=%0d rdata2=%h want 0/66", pending_cnt_o, rd(2));
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    write_i = 1'b1; waddr_i = 5'd8; wdata_i = 32'hA5A5A5A5;
    step();
    idle();
    issue_i = 1'b1; issue_rd_i = 5'd11; step();
    issue_rd_i = 5'd12; step();
    issue_rd_i = 5'd13; step();
    idle();
    raddr_i = pk(5'd8, 5'd11, 5'd12, 5'd13); rvalid_i = 4'b1111;
    #1;
    n_total++;
    if (pending_cnt_o !== 6'd3 || stall_o !== 1'b1 || rd(0) !== 32'hA5A5A5A5)
      $display("FAIL mid_reset_pre: cnt=%0d stall=%b rdata0=%h want 3/1/a5a5a5a5", pending_cnt_o, stall_o, rd(0));
    else n_pass++;
    #1;
    rst_i = 1'b1;
    #1;
    n_total++;
    if (rdata_o !== '0 || busy_o !== 4'b0000 || stall_o !== 1'b0 || pending_cnt_o !== 6'd0)
      $display("FAIL mid_reset_async: rdata=%h busy=%b stall=%b cnt=%0d want 0/0000/0/0",
               rdata_o, busy_o, stall_o, pending_cnt_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_raw_hazard();
    test_flush();
    test_same_edge();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fwd_regfile.md
Name: fwd_regfile

Overview:
- Parametrised general-purpose register file for the pipelined core, replacing the fixed 2-read/1-write file.
- Adds N read ports with write-through bypass and a pending-write scoreboard, so the decode stage can detect RAW hazards and stall.
- Sits between the ID/EX operand fetch and WB writeback. WB drives the write port, ID drives issue and read addresses, and stall_o feeds the pipeline control.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >= 2).
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREG), register address width (derived localparam, not overridable).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous active-high reset.
- write_i  in  1  writeback enable.
- waddr_i  in  AW  writeback destination register.
- wdata_i  in  XLEN  writeback data.
- raddr_i  in  NRD*AW  packed read addresses; port k is at bits [k*AW +: AW].
- rvalid_i  in  NRD  per-port "operand actually used" mask.
- rdata_o  out  NRD*XLEN  packed read data, port k at bits [k*XLEN +: XLEN].
- issue_i  in  1  an instruction with a destination register leaves ID this cycle.
- issue_rd_i  in  AW  destination of the issuing instruction.
- flush_i  in  1  clear all pending marks (branch/exception squash).
- busy_o  out  NRD  per-port source operand is pending.
- stall_o  out  1  OR over k of (busy_o[k] & rvalid_i[k]).
- pending_cnt_o  out  AW+1  number of registers currently marked pending.

Behaviour:
- Reset (async, rst_i=1): all NREG registers = 0, all pending bits = 0, pending_cnt_o = 0. Consequently rdata_o = 0, busy_o = 0, stall_o = 0.
- Register 0 is hardwired zero:
  - writes to it are ignored;
  - reads of it return 0;
  - it is never marked pending, so issue_rd_i = 0 has no effect.
- Write: on posedge with write_i=1 and waddr_i != 0, reg[waddr_i] <= wdata_i and pending[waddr_i] <= 0.
- Read: combinational, zero latency.
  - rdata_k = (write_i && waddr_i == raddr_k && raddr_k != 0) ? wdata_i : reg[raddr_k].
  - The bypass applies independently on every port.
- Issue: on posedge with issue_i=1 and issue_rd_i != 0, pending[issue_rd_i] <= 1.
- Busy: busy_o[k] = pending[raddr_k] && !(write_i && waddr_i == raddr_k). A same-cycle write clears the hazard because the bypass supplies the data.
- Simultaneous events on the same clock edge:
  - write and issue to the same register: the data is written and pending ends at 1 (the issue is younger, so it wins).
  - flush_i=1: all pending bits <= 0 and the same-cycle issue is discarded. The same-cycle write still updates the register.
  - issue to an already-pending register: it stays pending with no double count.
- pending_cnt_o is a registered popcount of the pending vector, updated on the same edge as pending. Range 0..NREG-1. Increment/decrement is computed from the next-state vector, never accumulated separately, so it cannot drift.
- rvalid_i only gates stall_o; busy_o is reported unmasked.
- Out-of-range addresses cannot occur because NREG is a power of two.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN default;
  - reg_addr_t typedef (logic [4:0]);
  - REG_ZERO constant;
  - popcount function, reused by other stages.
- One sub-module, reg_scoreboard, contains:
  - the pending vector, issue/write/flush priority, and pending_cnt;
  - ports clk_i, rst_i, set_i, set_addr_i, clr_i, clr_addr_i, flush_i, pending_o, cnt_o.
- fwd_regfile holds the storage array, bypass muxes, and busy/stall logic.

Test Plan:
- Reset mid-run with regs loaded and 3 pending: assert rst_i between edges -> rdata_o=0, busy_o=0, stall_o=0 and pending_cnt_o=0 immediately, without waiting for a clock.
- Write x5=0xDEADBEEF while reading raddr0=5 in the same cycle -> rdata0=0xDEADBEEF combinationally. Next cycle with write_i=0 -> still 0xDEADBEEF.
- Write x0=0x1234 and issue rd=0, then read x0 -> rdata=0, busy=0, pending_cnt_o=0.
- Issue rd=7, then read raddr1=7 with rvalid_i[1]=1 -> busy_o[1]=1, stall_o=1, pending_cnt_o=1. Write x7=0x42 -> busy_o[1]=0 in that cycle with rdata1=0x42; after the edge, cnt=0.
- Issue rd=3, rd=4, rd=9 on consecutive cycles (cnt=3). Then flush_i=1 together with issue rd=10 and write x3=0x99 -> after the edge cnt=0, x10 is not pending, x3=0x99.
- Same-edge write x6=0x55 and issue rd=6 with NRD=4, raddr all = 6, rvalid_i=4'b0001 -> after the edge rdata all = 0x55, busy_o=4'b1111, stall_o=1.
